scroll_engine: RTL and testbench

//  Multi-lane vertical scroll generator for the crossy-road playfield. Produces LANES independent
//  y offsets advancing at per-lane (parallax) rates while the move button is held, with true

---
 rtl/scroll_engine_if.sv | 29 ++
 rtl/scroll_engine.sv | 215 +++++++++++++++++++++
 tb/tb_scroll_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/scroll_engine_if.sv
// Bus bundle for the scroll engine: control inputs from the button front end
// and the lane positions / score consumed by the renderers and HUD.
interface scroll_engine_if #(
  parameter int LANES  = 4,
  parameter int Y_W    = 10,
  parameter int DIGITS = 3
);
  logic [LANES*Y_W-1:0] start_y;
  logic                 move_btn;
  logic                 dir;
  logic [1:0]           speed_sel;
  logic [LANES*Y_W-1:0] y_pos;
  logic [LANES-1:0]     wrap;
  logic                 tick;
  logic [4*DIGITS-1:0]  score;
  logic                 score_max;

  // Drives the engine (button logic / testbench side)
  modport master (
    output start_y, move_btn, dir, speed_sel,
    input  y_pos, wrap, tick, score, score_max
  );

  // The scroll engine itself
  modport slave (
    input  start_y, move_btn, dir, speed_sel,
    output y_pos, wrap, tick, score, score_max
  );
endinterface

// File: rtl/scroll_engine.sv
// Multi-lane vertical scroll generator: per-lane parallax y offsets that
// advance once per movement tick while the move button is held, wrap
// modulo the screen height in both directions, and a saturating BCD score.
module scroll_engine #(
  parameter int LANES       = 4,
  parameter int Y_W         = 10,
  parameter int SCREEN_H    = 480,
  parameter int TICK_DIV    = 250000,
  parameter int STEP        = 2,
  parameter int STEP_INC    = 1,
  parameter int SCORE_TICKS = 100,
  parameter int DIGITS      = 3
) (
  input  logic          clk,
  input  logic          reset,
  scroll_engine_if.slave bus
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W    = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
  localparam int SCORE_W = 4 * DIGITS;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]    SC_LAST   = SC_W'(SCORE_TICKS - 1);
  localparam logic [Y_W:0]       SCREEN    = (Y_W + 1)'(SCREEN_H);
  localparam logic [SCORE_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  // The largest per-lane base step must fit inside one screen height.
  if (STEP + (LANES - 1) * STEP_INC >= SCREEN_H) begin : g_step_check
    $error("scroll_engine: lane step must be smaller than SCREEN_H");
  end
  if (SCREEN_H > (1 << Y_W)) begin : g_height_check
    $error("scroll_engine: SCREEN_H does not fit in Y_W bits");
  end

  // Per-lane displacement for a speed setting. Reduced modulo the screen
  // height so that an oversized shifted step still wraps correctly.
  function automatic logic [Y_W-1:0] lane_delta(input int lane, input int sel);
    int raw;
    raw = (STEP + lane * STEP_INC) << sel;
    return Y_W'(raw % SCREEN_H);
  endfunction

  // BCD increment with rippling carry; an all-9s value saturates.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] val);
    logic [SCORE_W-1:0] res;
    logic               carry;
    res   = val;
    carry = 1'b1;
    if (val != ALL_NINES) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          if (res[4*k +: 4] == 4'd9) begin
            res[4*k +: 4] = 4'd0;
          end else begin
            res[4*k +: 4] = res[4*k +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end else begin
      res = val;
    end
    return res;
  endfunction

  logic                 move_active_r;
  logic [DIV_W-1:0]     div_r;
  logic [SC_W-1:0]      score_cnt_r;
  logic [LANES*Y_W-1:0] y_pos_r;
  logic [LANES-1:0]     wrap_r;
  logic                 tick_r;
  logic [SCORE_W-1:0]   score_r;
  logic                 score_max_r;

  logic                 tick_s;
  logic [DIV_W-1:0]     div_next_s;
  logic [LANES*Y_W-1:0] y_init_s;
  logic [LANES*Y_W-1:0] y_next_s;
  logic [LANES-1:0]     wrap_next_s;
  logic [SC_W-1:0]      score_cnt_next_s;
  logic [SCORE_W-1:0]   score_next_s;

  // Tick divider: counts only while the button stays held, so a release
  // (or a cycle where movement is inactive) discards partial progress.
  always_comb begin
    tick_s     = 1'b0;
    div_next_s = '0;
    if (move_active_r && (div_r == DIV_LAST)) begin
      tick_s     = 1'b1;
      div_next_s = '0;
    end else if (move_active_r && bus.move_btn) begin
      div_next_s = div_r + DIV_W'(1);
    end else begin
      div_next_s = '0;
    end
  end

  // Lane stepping: modular add/subtract in Y_W+1 bits with wrap flags.
  always_comb begin
    logic [Y_W-1:0] d;
    logic [Y_W:0]   y_ext;
    logic [Y_W:0]   d_ext;
    logic [Y_W:0]   y_new;
    d           = '0;
    y_ext       = '0;
    d_ext       = '0;
    y_new       = '0;
    y_next_s    = y_pos_r;
    wrap_next_s = '0;
    for (int i = 0; i < LANES; i++) begin
      case (bus.speed_sel)
        2'd0:    d = lane_delta(i, 0);
        2'd1:    d = lane_delta(i, 1);
        2'd2:    d = lane_delta(i, 2);
        2'd3:    d = lane_delta(i, 3);
        default: d = lane_delta(i, 0);
      endcase
      y_ext = {1'b0, y_pos_r[i*Y_W +: Y_W]};
      d_ext = {1'b0, d};
      if (!tick_s) begin
        y_new = y_ext;
      end else if (bus.dir == 1'b0) begin
        if (y_ext + d_ext >= SCREEN) begin
          y_new          = y_ext + d_ext - SCREEN;
          wrap_next_s[i] = 1'b1;
        end else begin
          y_new = y_ext + d_ext;
        end
      end else begin
        if (y_ext < d_ext) begin
          y_new          = y_ext + SCREEN - d_ext;
          wrap_next_s[i] = 1'b1;
        end else begin
          y_new = y_ext - d_ext;
        end
      end
      y_next_s[i*Y_W +: Y_W] = y_new[Y_W-1:0];
    end
  end

  // Reset positions: out-of-range start values are clamped to the top.
  always_comb begin
    y_init_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if ({1'b0, bus.start_y[i*Y_W +: Y_W]} < SCREEN) begin
        y_init_s[i*Y_W +: Y_W] = bus.start_y[i*Y_W +: Y_W];
      end else begin
        y_init_s[i*Y_W +: Y_W] = '0;
      end
    end
  end

  // Score pacing: one BCD increment every SCORE_TICKS movement ticks.
  always_comb begin
    score_cnt_next_s = score_cnt_r;
    score_next_s     = score_r;
    if (tick_s) begin
      if (score_cnt_r == SC_LAST) begin
        score_cnt_next_s = '0;
        score_next_s     = bcd_inc(score_r);
      end else begin
        score_cnt_next_s = score_cnt_r + SC_W'(1);
      end
    end else begin
      score_cnt_next_s = score_cnt_r;
    end
  end

  // Movement enable and divider state.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_active_r <= 1'b0;
      div_r         <= '0;
    end else begin
      move_active_r <= bus.move_btn;
      div_r         <= div_next_s;
    end
  end

  // Lane positions with their coincident tick/wrap pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_pos_r <= y_init_s;
      wrap_r  <= '0;
      tick_r  <= 1'b0;
    end else begin
      y_pos_r <= y_next_s;
      wrap_r  <= wrap_next_s;
      tick_r  <= tick_s;
    end
  end

  // Score counter, BCD score and saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_cnt_r <= '0;
      score_r     <= '0;
      score_max_r <= 1'b0;
    end else begin
      score_cnt_r <= score_cnt_next_s;
      score_r     <= score_next_s;
      score_max_r <= (score_next_s == ALL_NINES);
    end
  end

  assign bus.y_pos     = y_pos_r;
  assign bus.wrap      = wrap_r;
  assign bus.tick      = tick_r;
  assign bus.score     = score_r;
  assign bus.score_max = score_max_r;

endmodule

// File: tb/tb_scroll_engine.sv
// Directed testbench for scroll_engine with a small playfield
// (2 lanes, 16-line screen, 4-cycle tick, lane steps 3 and 4, score every 3 ticks).
module tb_scroll_engine;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  scroll_engine_if #(.LANES(2), .Y_W(5), .DIGITS(2)) bus ();

  scroll_engine #(
    .LANES(2), .Y_W(5), .SCREEN_H(16), .TICK_DIV(4), .STEP(3),
    .STEP_INC(1), .SCORE_TICKS(3), .DIGITS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle reset with the given lane start positions, inputs idle.
  task automatic do_reset(input logic [4:0] s1, input logic [4:0] s0);
    bus.start_y   = {s1, s0};
    bus.move_btn  = 1'b0;
    bus.dir       = 1'b0;
    bus.speed_sel = 2'd0;
    reset         = 1'b1;
    step_n(1);
    reset         = 1'b0;
  endtask

  task automatic test_reset;
    bus.start_y   = {5'd20, 5'd5};
    bus.move_btn  = 1'b1;
    bus.dir       = 1'b0;
    bus.speed_sel = 2'd0;
    reset         = 1'b1;
    step_n(2);
    checks++; if (bus.y_pos !== {5'd0, 5'd5}) begin errors++; $display("FAIL reset_y: got %h expected %h", bus.y_pos, {5'd0, 5'd5}); end
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL reset_score: got %h expected 00", bus.score); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", bus.tick); end
    checks++; if (bus.wrap !== 2'b00) begin errors++; $display("FAIL reset_wrap: got %b expected 00", bus.wrap); end
    checks++; if (bus.score_max !== 1'b0) begin errors++; $display("FAIL reset_score_max: got %b expected 0", bus.score_max); end
    reset        = 1'b0;
    bus.move_btn = 1'b0;
  endtask

  task automatic test_first_tick;
    do_reset(5'd5, 5'd0);
    bus.move_btn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step_n(1);
      checks++; if (bus.tick !== 1'b0 || bus.y_pos !== {5'd5, 5'd0}) begin errors++; $display("FAIL early_tick cycle %0d: tick=%b y=%h expected tick=0 y=%h", i, bus.tick, bus.y_pos, {5'd5, 5'd0}); end
    end
    step_n(1);
    checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b expected 1", bus.tick); end
    checks++; if (bus.y_pos !== {5'd9, 5'd3}) begin errors++; $display("FAIL first_tick_y: got %h expected %h", bus.y_pos, {5'd9, 5'd3}); end
    checks++; if (bus.wrap !== 2'b00) begin errors++; $display("FAIL first_tick_wrap: got %b expected 00", bus.wrap); end
    step_n(1);
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL tick_pulse_width: got %b expected 0", bus.tick); end
    bus.move_btn = 1'b0;
  endtask

  task automatic test_wrap_down;
    do_reset(5'd14, 5'd1);
    bus.move_btn = 1'b1;
    step_n(5);
    checks++; if (bus.y_pos !== {5'd2, 5'd4}) begin errors++; $display("FAIL down_wrap_y: got %h expected %h", bus.y_pos, {5'd2, 5'd4}); end
    checks++; if (bus.wrap !== 2'b10) begin errors++; $display("FAIL down_wrap_flag: got %b expected 10", bus.wrap); end
    step_n(1);
    checks++; if (bus.wrap !== 2'b00) begin errors++; $display("FAIL down_wrap_pulse: got %b expected 00", bus.wrap); end
    bus.speed_sel = 2'd1;
    step_n(2);
    checks++; if (bus.y_pos !== {5'd2, 5'd4} || bus.tick !== 1'b0) begin errors++; $display("FAIL between_ticks: y=%h tick=%b expected y=%h tick=0", bus.y_pos, bus.tick, {5'd2, 5'd4}); end
    step_n(1);
    checks++; if (bus.y_pos !== {5'd10, 5'd10}) begin errors++; $display("FAIL speed_change_y: got %h expected %h", bus.y_pos, {5'd10, 5'd10}); end
    checks++; if (bus.tick !== 1'b1 || bus.wrap !== 2'b00) begin errors++; $display("FAIL speed_change_pulse: tick=%b wrap=%b expected tick=1 wrap=00", bus.tick, bus.wrap); end
    bus.move_btn = 1'b0;
  endtask

  task automatic test_speed;
    do_reset(5'd3, 5'd1);
    bus.speed_sel = 2'd1;
    bus.move_btn  = 1'b1;
    step_n(5);
    checks++; if (bus.y_pos !== {5'd11, 5'd7}) begin errors++; $display("FAIL speed1_y: got %h expected %h", bus.y_pos, {5'd11, 5'd7}); end
    bus.move_btn = 1'b0;
  endtask

  task automatic test_wrap_up;
    do_reset(5'd4, 5'd1);
    bus.dir      = 1'b1;
    bus.move_btn = 1'b1;
    step_n(5);
    checks++; if (bus.y_pos !== {5'd0, 5'd14}) begin errors++; $display("FAIL up_wrap_y: got %h expected %h", bus.y_pos, {5'd0, 5'd14}); end
    checks++; if (bus.wrap !== 2'b01) begin errors++; $display("FAIL up_wrap_flag: got %b expected 01", bus.wrap); end
    step_n(4);
    checks++; if (bus.y_pos !== {5'd12, 5'd11}) begin errors++; $display("FAIL up_second_y: got %h expected %h", bus.y_pos, {5'd12, 5'd11}); end
    checks++; if (bus.wrap !== 2'b10) begin errors++; $display("FAIL up_second_wrap: got %b expected 10", bus.wrap); end
    bus.move_btn = 1'b0;
  endtask

  task automatic test_boundary;
    do_reset(5'd12, 5'd13);
    bus.move_btn = 1'b1;
    step_n(5);
    checks++; if (bus.y_pos !== {5'd0, 5'd0}) begin errors++; $display("FAIL exact_screen_y: got %h expected %h", bus.y_pos, {5'd0, 5'd0}); end
    checks++; if (bus.wrap !== 2'b11) begin errors++; $display("FAIL exact_screen_wrap: got %b expected 11", bus.wrap); end
    bus.move_btn = 1'b0;
  endtask

  task automatic test_release;
    do_reset(5'd0, 5'd0);
    bus.move_btn = 1'b1;
    step_n(3);
    bus.move_btn = 1'b0;
    step_n(1);
    bus.move_btn = 1'b1;
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL release_no_tick: got %b expected 0", bus.tick); end
    for (int i = 5; i <= 8; i++) begin
      step_n(1);
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL repress_early_tick cycle %0d: got %b expected 0", i, bus.tick); end
    end
    step_n(1);
    checks++; if (bus.tick !== 1'b1 || bus.y_pos !== {5'd4, 5'd3}) begin errors++; $display("FAIL repress_tick: tick=%b y=%h expected tick=1 y=%h", bus.tick, bus.y_pos, {5'd4, 5'd3}); end
    bus.move_btn = 1'b0;
  endtask

  task automatic test_score;
    do_reset(5'd0, 5'd0);
    bus.move_btn = 1'b1;
    step_n(13);
    checks++; if (bus.tick !== 1'b1 || bus.score !== 8'h01) begin errors++; $display("FAIL score_3_ticks: tick=%b score=%h expected tick=1 score=01", bus.tick, bus.score); end
    step_n(24);
    checks++; if (bus.score !== 8'h03) begin errors++; $display("FAIL score_9_ticks: got %h expected 03", bus.score); end
    bus.move_btn = 1'b0;
  endtask

  task automatic test_saturate;
    do_reset(5'd0, 5'd0);
    bus.move_btn = 1'b1;
    step_n(121);
    checks++; if (bus.score !== 8'h10) begin errors++; $display("FAIL score_carry: got %h expected 10", bus.score); end
    step_n(1056);
    checks++; if (bus.score !== 8'h98 || bus.score_max !== 1'b0) begin errors++; $display("FAIL score_98: score=%h max=%b expected 98/0", bus.score, bus.score_max); end
    step_n(12);
    checks++; if (bus.score !== 8'h99 || bus.score_max !== 1'b1) begin errors++; $display("FAIL score_99: score=%h max=%b expected 99/1", bus.score, bus.score_max); end
    step_n(12);
    checks++; if (bus.score !== 8'h99 || bus.score_max !== 1'b1) begin errors++; $display("FAIL score_saturate: score=%h max=%b expected 99/1", bus.score, bus.score_max); end
    step_n(2);
    bus.start_y = {5'd7, 5'd6};
    reset       = 1'b1;
    step_n(1);
    reset       = 1'b0;
    checks++; if (bus.score !== 8'h00 || bus.score_max !== 1'b0) begin errors++; $display("FAIL midrun_reset_score: score=%h max=%b expected 00/0", bus.score, bus.score_max); end
    checks++; if (bus.y_pos !== {5'd7, 5'd6} || bus.tick !== 1'b0 || bus.wrap !== 2'b00) begin errors++; $display("FAIL midrun_reset_state: y=%h tick=%b wrap=%b expected y=%h tick=0 wrap=00", bus.y_pos, bus.tick, bus.wrap, {5'd7, 5'd6}); end
    step_n(4);
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL post_reset_early_tick: got %b expected 0", bus.tick); end
    step_n(1);
    checks++; if (bus.tick !== 1'b1 || bus.y_pos !== {5'd11, 5'd9}) begin errors++; $display("FAIL post_reset_tick: tick=%b y=%h expected tick=1 y=%h", bus.tick, bus.y_pos, {5'd11, 5'd9}); end
    bus.move_btn = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.start_y   = '0;
    bus.move_btn  = 1'b0;
    bus.dir       = 1'b0;
    bus.speed_sel = 2'd0;
    test_reset();
    test_first_tick();
    test_wrap_down();
    test_speed();
    test_wrap_up();
    test_boundary();
    test_release();
    test_score();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
